// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRL  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/xor_32bit.sv
// Bitwise XOR of two operands; used as the XOR path of the sequential ALU.
module xor_32bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/alu_32bit_seq.sv
// Handshaked ALU: logic and add/sub resolve at accept, shifts iterate one bit per cycle,
// and the result is held until the consumer takes it.
module alu_32bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] xor_y;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   amt;
  logic             carry_q;
  logic             err_q;
  logic             dir_left;
  logic             accept;
  logic             is_shift;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  xor_32bit #(.WIDTH(WIDTH)) u_xor (
    .a (a),
    .b (b),
    .y (xor_y)
  );

  assign amt      = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL);
  assign accept   = in_valid && in_ready;
  assign sum      = {1'b0, a} + {1'b0, b};
  // Subtraction as a + ~b + 1, so the top bit is the no-borrow flag.
  assign diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (is_shift && amt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt == SHW'(1)) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !rst;
    out_valid = (state == ST_DONE);
  end

  // Result register doubles as the shift register; operands are consumed at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      res      <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= '0;
      dir_left <= 1'b0;
    end else if (accept) begin
      err_q    <= (op == OP_RSVD);
      carry_q  <= 1'b0;
      cnt      <= amt;
      dir_left <= (op == OP_SLL);
      case (op)
        OP_AND:  res <= a & b;
        OP_OR:   res <= a | b;
        OP_XOR:  res <= xor_y;
        OP_ADD:  {carry_q, res} <= sum;
        OP_SUB:  {carry_q, res} <= diff;
        OP_SLL:  res <= a;
        OP_SRL:  res <= a;
        default: res <= '0;
      endcase
    end else if (state == ST_SHIFT) begin
      res <= dir_left ? (res << 1) : (res >> 1);
      cnt <= cnt - SHW'(1);
    end
  end

  assign y     = res;
  assign carry = carry_q;
  assign zero  = (res == '0);
  assign err   = err_q;

endmodule

// File: tb/tb_alu_32bit_seq.sv
// Directed self-checking bench for alu_32bit_seq: latency, flags, backpressure, reset abort.
module tb_alu_32bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        carry;
  logic        zero;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_32bit_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for acceptance, then scramble the inputs.
  task automatic send(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    int k = 0;
    while (!in_ready && k < 60) begin
      tick();
      k++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    op = o; a = x; b = z; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = 3'b000; a = 32'hDEADBEEF; b = 32'h12345678;
  endtask

  // Cycles from the accept edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk("done_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 3'b000; a = '0; b = '0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // XOR
    send(3'b010, 32'h5, 32'hFFFFFFFD);
    wait_done(lat);
    chk("xor_lat", 32'(lat), 32'd1);
    chk("xor_y", y, 32'hFFFFFFF8);
    chk("xor_zero", 32'(zero), 32'd0);
    chk("xor_carry", 32'(carry), 32'd0);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_y_hold", y, 32'hFFFFFFF8);

    // ADD wrap, SUB borrow and no-borrow
    send(3'b011, 32'hFFFFFFFF, 32'h1);
    wait_done(lat);
    chk("add_y", y, 32'd0);
    chk("add_carry", 32'(carry), 32'd1);
    chk("add_zero", 32'(zero), 32'd1);
    tick();
    send(3'b100, 32'd3, 32'd5);
    wait_done(lat);
    chk("sub_lat", 32'(lat), 32'd1);
    chk("sub_y", y, 32'hFFFFFFFE);
    chk("sub_carry", 32'(carry), 32'd0);
    tick();
    send(3'b100, 32'd5, 32'd3);
    wait_done(lat);
    chk("sub2_y", y, 32'd2);
    chk("sub2_carry", 32'(carry), 32'd1);
    tick();
    send(3'b001, 32'hF0F0_0000, 32'h0000_0F0F);
    wait_done(lat);
    chk("or_y", y, 32'hF0F00F0F);
    tick();

    // Shifts
    send(3'b101, 32'h1, 32'd31);
    wait_done(lat);
    chk("sll31_lat", 32'(lat), 32'd32);
    chk("sll31_y", y, 32'h80000000);
    chk("sll31_carry", 32'(carry), 32'd0);
    tick();
    send(3'b110, 32'hABCD1234, 32'h20);
    wait_done(lat);
    chk("srl0_lat", 32'(lat), 32'd1);
    chk("srl0_y", y, 32'hABCD1234);
    tick();
    send(3'b110, 32'hF0000000, 32'd4);
    wait_done(lat);
    chk("srl4_lat", 32'(lat), 32'd5);
    chk("srl4_y", y, 32'h0F000000);
    tick();

    // Backpressure with a competing request
    out_ready = 1'b0;
    send(3'b000, 32'hFF00FF00, 32'h0FF00FF0);
    wait_done(lat);
    held = y;
    chk("bp_y", y, 32'h0F000F00);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; op = 3'b011; a = 32'h1; b = 32'h1;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_y_stable", y, held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_y", y, 32'h0F000F00);

    // Reset in the middle of a long shift
    send(3'b110, 32'hF0000000, 32'd20);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst_y", y, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    chk("midrst_carry", 32'(carry), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen = seen | out_valid;
      tick();
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    send(3'b000, 32'hFF, 32'h0F);
    wait_done(lat);
    chk("after_rst_and", y, 32'h0F);
    tick();

    // Reserved op, then a valid op clears err
    send(3'b111, 32'h1234, 32'h1);
    wait_done(lat);
    chk("rsvd_err", 32'(err), 32'd1);
    chk("rsvd_y", y, 32'd0);
    chk("rsvd_zero", 32'(zero), 32'd1);
    chk("rsvd_carry", 32'(carry), 32'd0);
    tick();
    send(3'b001, 32'h1, 32'h2);
    wait_done(lat);
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_y", y, 32'h3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
